// File: rtl/uart_byte_tx.sv
// uart_byte_tx: absorbs splitter bytes in a small FIFO with no backpressure and
// serializes each one as a start / 8 data (LSB first) / stop frame on tx.
// The frame advances one line level per ce tick. A byte that arrives while the
// FIFO is full is dropped, and the drop is latched on the sticky overflow flag.
module uart_byte_tx #(
  parameter int FIFO_DEPTH = 4,  // power of two, >= 2
  parameter int STOP_BITS  = 1   // 1 or 2
) (
  input  logic                          clk,
  input  logic                          rst,        // synchronous, active-low
  input  logic                          ce,
  input  logic                          byte_dv,
  input  logic [7:0]                    byteee,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C   = FIFO_DEPTH[AW:0];
  localparam logic           STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            stop_cnt;

  logic            full;
  logic            wr_en;
  logic            pop;

  // The full check uses the occupancy from the start of the cycle, so a pop in
  // the same cycle never frees room for that cycle's write.
  assign full  = (fifo_count == DEPTH_C);
  assign wr_en = byte_dv && !full;

  // A new frame is fetched on a ce tick from IDLE, or at the end of the last
  // stop period so that queued frames go out back-to-back.
  assign pop = ce && (fifo_count != '0) &&
               ((state == IDLE) || ((state == STOP) && (stop_cnt == STOP_LAST)));

  assign busy = (state != IDLE) || (fifo_count != '0);

  // Byte storage. byteee is only sampled behind byte_dv, so an undriven bus
  // while byte_dv is low never reaches the array.
  // NOTE: the storage array has no reset; the cleared pointers and count make
  // stale contents unreachable, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= byteee;
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, which the same-cycle push/pop rules depend on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (byte_dv && full) overflow <= 1'b1;
    end
  end

  // Frame FSM with registered tx; it only moves on ce ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          tx      <= shift[0];
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt != 3'd7) begin
            bit_cnt <= bit_cnt + 1'b1;
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
          end else begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (stop_cnt != STOP_LAST) begin
            stop_cnt <= stop_cnt + 1'b1;
          end else if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Transmit-side stage that sits directly downstream of the word-to-byte splitter and consumes its byte stream.
- The splitter emits byte_dv pulses with no backpressure, up to two on consecutive cycles. This block absorbs them in a small FIFO.
- It then serializes each byte as an 8N1-style UART frame on tx, one bit per ce tick.
- Drops caused by a full FIFO are flagged on a sticky overflow output.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
- STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- ce  input  1  bit-rate tick, one-cycle pulse; the frame advances only on cycles with ce=1.
- byte_dv  input  1  byte valid strobe, one write per high cycle.
- byteee  input  8  byte data, sampled when byte_dv=1.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high when state != IDLE or fifo_count != 0.
- overflow  output  1  sticky; set when a byte is dropped, cleared only by reset.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0 at a clk edge) applies regardless of ce and interrupts any frame in progress:
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FIFO pointers cleared; state=IDLE; shift register and bit/stop counters cleared.
- FIFO write:
  - On byte_dv=1, byteee is written if fifo_count < FIFO_DEPTH at the start of the cycle. fifo_count is +1 at the next edge.
  - If full, the byte is dropped and overflow is set at the next edge.
  - A pop in the same cycle does not free space for that cycle's write (the full check uses the pre-cycle count).
- Simultaneous write and pop: both take effect; fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- The FSM is registered and acts only on cycles with ce=1; on ce=0 every register except the FIFO holds.
  - IDLE: tx=1.
    - ce=1 and fifo_count>0: pop head into the shift register, tx<=0, go START.
    - Otherwise stay in IDLE.
    - A byte written in the same cycle as an IDLE ce tick with an empty FIFO is not seen until the next ce.
  - START: on ce, tx<=shift[0], bit_cnt<=0, go DATA.
  - DATA: on ce:
    - bit_cnt<7: bit_cnt+1, tx<=next bit (LSB first).
    - bit_cnt=7: tx<=1, stop_cnt<=0, go STOP.
  - STOP: on ce:
    - stop_cnt<STOP_BITS-1: increment.
    - Otherwise, if fifo_count>0: pop, tx<=0, go START (back-to-back, no idle bit).
    - Otherwise go IDLE, tx stays 1.
- Frame timing:
  - Each line level is held exactly one ce period.
  - A frame is 1 start + 8 data + STOP_BITS stop = 10 or 11 ce periods.
  - Latency from first ce in IDLE with data to the start-bit edge is 1 clk.
- busy drops to 0 the cycle after the FSM enters IDLE with fifo_count=0.
- byteee is ignored when byte_dv=0. X on byteee with byte_dv=0 must not propagate.

Test Plan:
- Single byte, ce every 4 clk:
  - Stimulus: byte_dv=1 with byteee=0xA5, then ce runs.
  - Required: tx per ce period = 0,1,0,1,0,0,1,0,1,1, then idle 1.
  - Required: busy high from the cycle after the write until 1 clk after the stop period ends.
- Splitter burst:
  - Stimulus: byte_dv on two consecutive cycles with 0x34 then 0x12.
  - Required: fifo_count goes 1 then 2.
  - Required: two frames back-to-back, 20 ce periods, no idle high between stop and start.
  - Required: bytes in order 0x34 then 0x12.
- Overflow, FIFO_DEPTH=4, ce held 0:
  - Stimulus: push 0x01..0x06 on consecutive cycles.
  - Required: fifo_count=4 and overflow=1 after the 5th push.
  - Required: after enabling ce, only 0x01..0x04 are transmitted; overflow stays 1.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, push in the same cycle as an IDLE ce pop.
  - Required: pushed byte dropped, overflow=1, fifo_count=3.
- Reset mid-frame:
  - Stimulus: rst=0 during DATA bit 3 of 0xFF with 2 bytes queued.
  - Required: next edge gives tx=1, fifo_count=0, busy=0.
  - Required: no further frames after rst=1 without new writes.
- STOP_BITS=2:
  - Stimulus: two queued bytes 0x00, 0x80.
  - Required: each frame is 11 ce periods, with two stop-high periods before the second start bit.
